// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver. It synchronises and glitch-filters the pins,
// deframes and validates 11-bit frames, folds E0/F0 prefixes into flags, and
// buffers key events in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 pins
//   key_code/ext/break  event at the FIFO head (zero while key_valid is low)
//   key_valid/key_ready valid/ready handshake; pop when both are high
//   frame_err           one-cycle pulse per rejected or aborted frame
//   overflow            one-cycle pulse per event dropped on a full FIFO

// ps2_key_fifo: generic first-word-fall-through FIFO, power-of-two depth.
// Latency: a write into an empty FIFO is visible on rd_dat/rd_vld the next cycle.
// Backpressure: a write while full is accepted only with a same-cycle read, otherwise wr_drop.
module ps2_key_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_drop,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  // One bit wider than the pointers so that full and empty are distinct.
  logic [AW:0]   count;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_vld  = (count != '0);
  assign rd_en   = rd_vld & rd_rdy;
  // A read in the same cycle frees the slot the write needs.
  assign wr_en   = wr_vld & (~full | rd_en);
  assign wr_drop = wr_vld & full & ~rd_en;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// ps2_key_rx: PS/2 pins to validated, prefix-decoded key events.
// Latency: pin edge to filtered edge 2+FILTER_LEN cycles; stop-bit sample to key_valid 2 cycles.
// Backpressure: key_ready stalls the FIFO head; events arriving while full are dropped with overflow.
module ps2_key_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [3:0] STOP_BIT = 4'd10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [0:0] {
    IDLE,
    RECV
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and clock glitch filter
  // ---------------------------------------------------------------------------
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt_clk, filt_clk_q;
  logic [FW-1:0] filt_cnt;
  logic          sample_evt;
  logic          sample_bit;

  // The filtered clock only follows the synchronised level once it has
  // disagreed for FILTER_LEN consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      filt_clk   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      filt_clk_q <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Falling edge of the filtered clock; the data line has long settled by now
  // because the filter delay is far shorter than the PS/2 low phase.
  assign sample_evt = filt_clk_q & ~filt_clk;
  assign sample_bit = dat_s2;

  // ---------------------------------------------------------------------------
  // Frame FSM, watchdog and prefix decoding
  // ---------------------------------------------------------------------------
  state_t        state, state_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [8:0]    shift, shift_d;     // {parity, data[7:0]} once bits 1..9 are in
  logic [WW-1:0] wd_cnt, wd_cnt_d;
  logic          ext_pend, ext_pend_d;
  logic          brk_pend, brk_pend_d;
  logic          err_d;
  logic          push_vld, push_vld_d;
  key_evt_t      push_evt, push_evt_d;
  logic          frame_ok;

  // Odd parity across data+parity, and the stop bit (arriving now) must be high.
  assign frame_ok = (^shift) & sample_bit;

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift;
    wd_cnt_d   = wd_cnt;
    ext_pend_d = ext_pend;
    brk_pend_d = brk_pend;
    err_d      = 1'b0;
    push_vld_d = 1'b0;
    push_evt_d = push_evt;

    case (state)
      IDLE: begin
        wd_cnt_d = '0;
        if (sample_evt) begin
          if (!sample_bit) begin
            state_d   = RECV;
            bit_cnt_d = 4'd1;
          end else begin
            // A start bit of 1 means we are out of step with the keyboard.
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end
      end

      RECV: begin
        if (sample_evt) begin
          wd_cnt_d = '0;
          if (bit_cnt == STOP_BIT) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (frame_ok) begin
              if (shift[7:0] == CODE_EXT) begin
                ext_pend_d = 1'b1;
              end else if (shift[7:0] == CODE_BRK) begin
                brk_pend_d = 1'b1;
              end else begin
                push_vld_d      = 1'b1;
                push_evt_d.ext  = ext_pend;
                push_evt_d.brk  = brk_pend;
                push_evt_d.code = shift[7:0];
                ext_pend_d      = 1'b0;
                brk_pend_d      = 1'b0;
              end
            end else begin
              err_d      = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            // LSB arrives first, so shift in from the top.
            shift_d   = {sample_bit, shift[8:1]};
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
          // Keyboard stopped mid-frame: drop the partial byte and resync.
          state_d    = IDLE;
          bit_cnt_d  = '0;
          wd_cnt_d   = '0;
          err_d      = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          wd_cnt_d = wd_cnt + WW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        wd_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      wd_cnt    <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      frame_err <= 1'b0;
      push_vld  <= 1'b0;
      push_evt  <= '0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shift     <= shift_d;
      wd_cnt    <= wd_cnt_d;
      ext_pend  <= ext_pend_d;
      brk_pend  <= brk_pend_d;
      frame_err <= err_d;
      push_vld  <= push_vld_d;
      push_evt  <= push_evt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Key-event FIFO
  // ---------------------------------------------------------------------------
  key_evt_t head_dat;
  logic     head_vld;
  logic     push_drop;

  ps2_key_fifo #(
    .W     ($bits(key_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_vld  (push_vld),
    .wr_dat  (push_evt),
    .wr_drop (push_drop),
    .rd_vld  (head_vld),
    .rd_rdy  (key_ready),
    .rd_dat  (head_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= push_drop;
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign key_valid = head_vld;
  assign key_code  = head_vld ? head_dat.code : 8'h00;
  assign key_ext   = head_vld & head_dat.ext;
  assign key_break = head_vld & head_dat.brk;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: directed bench for ps2_key_rx (FILTER_LEN 4, TIMEOUT_CYCLES 200, FIFO_DEPTH 4).
// Drives PS/2 frames bit by bit, records popped events and error/overflow pulses,
// and compares them against hand-computed expectations.
module tb_ps2_key_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       frame_err;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] evq [$];

  ps2_key_rx #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (200),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
      if (key_valid && key_ready) evq.push_back({key_ext, key_break, key_code});
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic take_ev(output logic [31:0] e);
    if (evq.size() != 0) e = {22'd0, evq.pop_front()};
    else e = 32'hFFFF_FFFF;
  endtask

  task automatic ps2_bit(input logic d);
    ps2_data = d;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  // Sends the first nbits bits of a frame: start, data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~(^b)) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  logic [31:0] ev;
  int e0;
  int o0;

  initial begin
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);

    // Reset state
    check("rst_valid", 32'(key_valid), 0);
    check("rst_code", 32'(key_code), 0);
    check("rst_flags", 32'({key_ext, key_break}), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovf", 32'(overflow), 0);

    // Single 0x1C with stop-bit latency measured: filtered fall 6 cycles after
    // the pin, push one cycle later, visible the cycle after that.
    send_frame(8'h1C, 1'b0, 1'b1, 10);
    ps2_clk = 1'b0;
    wait_cyc(7);
    check("lat_not_yet", 32'(key_valid), 0);
    wait_cyc(1);
    check("lat_valid", 32'(key_valid), 1);
    check("lat_code", 32'(key_code), 32'h1C);
    wait_cyc(12);
    ps2_clk = 1'b1;
    wait_cyc(10);
    key_ready = 1'b1;
    wait_cyc(5);
    take_ev(ev);
    check("ev_1c", ev, 32'h01C);
    check("one_event", 32'(evq.size()), 0);
    check("no_ferr_1c", 32'(err_cnt), 0);

    // Prefix folding
    send_key(8'hF0);
    send_key(8'h1C);
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h75);
    check("prefix_cnt", 32'(evq.size()), 2);
    take_ev(ev);
    check("ev_brk_1c", ev, 32'h11C);
    take_ev(ev);
    check("ev_ext_brk_75", ev, 32'h375);

    // Parity and stop errors, then a good byte
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check("bad_frames_err", 32'(err_cnt - e0), 2);
    check("bad_frames_noev", 32'(evq.size()), 0);
    send_key(8'h32);
    take_ev(ev);
    check("ev_32", ev, 32'h032);
    // A frame error also discards a pending break prefix
    send_key(8'hF0);
    send_frame(8'h12, 1'b1, 1'b1, 11);
    send_key(8'h1C);
    take_ev(ev);
    check("err_clears_flag", ev, 32'h01C);
    check("err_total", 32'(err_cnt - e0), 3);

    // Watchdog
    e0 = err_cnt;
    send_frame(8'hAA, 1'b0, 1'b1, 5);
    wait_cyc(100);
    check("wd_early", 32'(err_cnt - e0), 0);
    wait_cyc(200);
    check("wd_fired", 32'(err_cnt - e0), 1);
    send_key(8'h2B);
    take_ev(ev);
    check("ev_2b", ev, 32'h02B);
    check("wd_after", 32'(err_cnt - e0), 1);

    // FIFO overflow
    key_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) send_key(8'(i));
    check("full_valid", 32'(key_valid), 1);
    check("full_head", 32'(key_code), 32'h01);
    check("ovf_once", 32'(ovf_cnt - o0), 1);
    key_ready = 1'b1;
    wait_cyc(8);
    key_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      take_ev(ev);
      check("drain_order", ev, 32'(i));
    end
    check("drain_empty", 32'(key_valid), 0);
    check("drain_cnt", 32'(evq.size()), 0);

    // Push while full with a pop in the same cycle
    for (int i = 0; i < 4; i++) send_key(8'h21 + 8'(i));
    send_frame(8'h25, 1'b0, 1'b1, 10);
    ps2_clk = 1'b0;
    wait_cyc(7);
    key_ready = 1'b1;
    wait_cyc(1);
    key_ready = 1'b0;
    wait_cyc(12);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("pop_push_no_ovf", 32'(ovf_cnt - o0), 1);
    take_ev(ev);
    check("pop_push_popped", ev, 32'h021);
    key_ready = 1'b1;
    wait_cyc(8);
    for (int i = 0; i < 4; i++) begin
      take_ev(ev);
      check("pop_push_order", ev, 32'h22 + 32'(i));
    end

    // Reset mid-frame with an event held in the FIFO
    key_ready = 1'b0;
    e0 = err_cnt;
    o0 = ovf_cnt;
    send_key(8'h11);
    check("pre_rst_valid", 32'(key_valid), 1);
    send_frame(8'h5A, 1'b0, 1'b1, 6);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(1);
    check("post_rst_valid", 32'(key_valid), 0);
    check("post_rst_code", 32'(key_code), 0);
    wait_cyc(300);
    check("post_rst_noerr", 32'(err_cnt - e0), 0);
    check("post_rst_noovf", 32'(ovf_cnt - o0), 0);
    key_ready = 1'b1;
    send_key(8'h4D);
    check("post_rst_cnt", 32'(evq.size()), 1);
    take_ev(ev);
    check("post_rst_ev", ev, 32'h04D);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Parametrised PS/2 keyboard receiver with full frame validation, prefix decoding and output buffering. It sits between the PS/2 connector pins and the key-entry logic that collects operands for the RSA datapath. Each received byte is checked for start, parity and stop errors, and aborted frames are detected by a watchdog. E0/F0 prefixes are folded into flags on the following byte, and the resulting key events are delivered through a valid/ready FIFO so no codes are lost while the consumer is busy.

## Interface
- FILTER_LEN, 8: consecutive equal samples needed before the filtered PS/2 clock changes level (≥2).
- TIMEOUT_CYCLES, 100000: idle cycles allowed between falling edges inside a frame before abort (≥16).
- FIFO_DEPTH, 4: key-event FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- key_code  out  8  scan code at the FIFO head.
- key_ext  out  1  head event was preceded by E0.
- key_break  out  1  head event was preceded by F0 (key release).
- key_valid  out  1  FIFO non-empty; head fields are valid.
- key_ready  in  1  consumer accepts the head when high with key_valid.
- frame_err  out  1  one-cycle pulse per rejected or aborted frame.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Reset: sync and filter flops = 1 (bus idle high), FSM = IDLE, bit count = 0, flags clear, FIFO empty. All outputs 0.
- Input path: 2-flop synchroniser on both pins. The filtered clock takes the synchronised level after FILTER_LEN consecutive cycles of that level. A sample event occurs on a filtered 1→0 transition, and data is taken from the synchronised ps2_data in that cycle.
- FSM IDLE: sample event with data 0 → RECV, count = 1. Data 1 → frame_err pulse, stay IDLE.
- FSM RECV: each sample event shifts in one bit. Bits 1–8 are data, LSB first. Bit 9 is parity. Bit 10 is stop. The frame is accepted only if data^parity has odd weight and stop = 1. Otherwise a frame_err pulse is issued. Either way the FSM returns to IDLE after bit 10.
- Watchdog: a counter runs in RECV and clears on each sample event. If it reaches TIMEOUT_CYCLES, the partial frame is discarded, frame_err pulses, and the FSM goes to IDLE.
- Prefix decode on an accepted byte:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte pushes {ext_pend, brk_pend, byte} and then clears both flags.
  - Any frame_err clears both flags.
- FIFO is first-word fall-through; the head is visible on the outputs while key_valid = 1. A pop occurs when key_valid & key_ready.
- Push when full without a same-cycle pop → event dropped and overflow pulses. Push when full with a same-cycle pop → both happen, no overflow. Push into an empty FIFO → key_valid rises the next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is tracked with an extra bit so the full and empty states are distinct.

## Timing
- Pin to filtered-clock change: 2 + FILTER_LEN cycles.
- Sample event of the stop bit in cycle N → push in N+1 → key_valid = 1 and head valid in N+2 when the FIFO was empty.
- frame_err is asserted in the cycle after the sample event or timeout that detects the error.
- overflow is asserted in the cycle after the dropped push.
- Pop takes effect at the clock edge. The next entry, or key_valid = 0, appears the following cycle.
- rst mid-frame or mid-FIFO aborts everything next edge: no frame_err, no overflow, FIFO flushed.

## Test plan
- Send 0x1C, odd parity, FILTER_LEN = 4, key_ready = 1 → exactly one event {code 0x1C, ext 0, break 0}, with no frame_err.
- Send F0 then 1C, then E0 F0 75 → events {1C, ext 0, break 1}, then {75, ext 1, break 1}. Prefix bytes produce no events.
- Send 0x1C with parity bit inverted, then with stop = 0 → two frame_err pulses, no events. A following valid 0x32 is delivered normally.
- Send 5 falling edges then stall for TIMEOUT_CYCLES = 200 → frame_err pulse at timeout. A following 0x2B frame is received correctly.
- FIFO_DEPTH = 4, key_ready = 0, send 5 codes → key_valid held high, one overflow pulse on the 5th, then 4 pops yield codes 1–4 in order. Separately, push while full with a same-cycle pop → no overflow.
- Assert rst for 1 cycle during bit 6 of a frame → outputs 0, no error pulse. The next full frame is received correctly.
